// File: rtl/regfile_access_ctrl.sv
// In-order read/write command sequencer in front of a 2R1W register file.
// Commands are FIFO-buffered and issued one at a time; read results return over valid/ready.
module regfile_access_ctrl #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic                  cmd_write_i,
    input  logic [ADDR_WIDTH-1:0] cmd_addr1_i,
    input  logic [ADDR_WIDTH-1:0] cmd_addr2_i,
    input  logic [DATA_WIDTH-1:0] cmd_wdata_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [DATA_WIDTH-1:0] rsp_rdata1_o,
    output logic [DATA_WIDTH-1:0] rsp_rdata2_o,
    output logic                  rf_we_o,
    output logic [ADDR_WIDTH-1:0] rf_waddr_o,
    output logic [DATA_WIDTH-1:0] rf_wdata_o,
    output logic [ADDR_WIDTH-1:0] rf_raddr1_o,
    output logic [ADDR_WIDTH-1:0] rf_raddr2_o,
    input  logic [DATA_WIDTH-1:0] rf_rdata1_i,
    input  logic [DATA_WIDTH-1:0] rf_rdata2_i,
    output logic                  busy_o,
    output logic                  wr_zero_o
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int EW = 1 + 2 * ADDR_WIDTH + DATA_WIDTH;

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        READ,
        RESP
    } state_e;

    state_e state_q, state_d;

    logic [EW-1:0] fifo_q [FIFO_DEPTH];
    logic [PW:0]   wptr_q, wptr_d;
    logic [PW:0]   rptr_q, rptr_d;
    logic          empty, full, push, pop;

    logic [EW-1:0]         head;
    logic                  head_write;
    logic [ADDR_WIDTH-1:0] head_a1, head_a2;
    logic [DATA_WIDTH-1:0] head_wd;

    logic                  rf_we_q, rf_we_d;
    logic [ADDR_WIDTH-1:0] rf_waddr_q, rf_waddr_d;
    logic [DATA_WIDTH-1:0] rf_wdata_q, rf_wdata_d;
    logic [ADDR_WIDTH-1:0] rf_raddr1_q, rf_raddr1_d;
    logic [ADDR_WIDTH-1:0] rf_raddr2_q, rf_raddr2_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_rdata1_q, rsp_rdata1_d;
    logic [DATA_WIDTH-1:0] rsp_rdata2_q, rsp_rdata2_d;
    logic                  wr_zero_q, wr_zero_d;

    // Full when indices match but wrap bits differ
    assign empty = (wptr_q == rptr_q);
    assign full  = (wptr_q[PW] != rptr_q[PW]) &&
                   (wptr_q[PW-1:0] == rptr_q[PW-1:0]);
    assign push  = cmd_valid_i && !full;
    assign pop   = (state_q == IDLE) && !empty;

    assign wptr_d = wptr_q + (PW + 1)'(push);
    assign rptr_d = rptr_q + (PW + 1)'(pop);

    assign head       = fifo_q[rptr_q[PW-1:0]];
    assign head_write = head[EW-1];
    assign head_a1    = head[EW-2 -: ADDR_WIDTH];
    assign head_a2    = head[DATA_WIDTH +: ADDR_WIDTH];
    assign head_wd    = head[DATA_WIDTH-1:0];

    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_q[wptr_q[PW-1:0]] <= {cmd_write_i, cmd_addr1_i,
                                       cmd_addr2_i, cmd_wdata_i};
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (!empty) state_d = head_write ? WRITE : READ;
            WRITE:   state_d = IDLE;
            READ:    state_d = RESP;
            RESP:    if (rsp_ready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rf_we_d      = 1'b0;
        rf_waddr_d   = rf_waddr_q;
        rf_wdata_d   = rf_wdata_q;
        rf_raddr1_d  = rf_raddr1_q;
        rf_raddr2_d  = rf_raddr2_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_rdata1_d = rsp_rdata1_q;
        rsp_rdata2_d = rsp_rdata2_q;
        wr_zero_d    = wr_zero_q;
        unique case (state_q)
            IDLE: begin
                if (!empty && head_write) begin
                    rf_we_d    = 1'b1;
                    rf_waddr_d = head_a1;
                    rf_wdata_d = head_wd;
                end else if (!empty) begin
                    rf_raddr1_d = head_a1;
                    rf_raddr2_d = head_a2;
                end
            end
            WRITE: begin
                if (rf_waddr_q == '0) wr_zero_d = 1'b1;
            end
            READ: begin
                rsp_rdata1_d = rf_rdata1_i;
                rsp_rdata2_d = rf_rdata2_i;
                rsp_valid_d  = 1'b1;
            end
            RESP: begin
                if (rsp_ready_i) rsp_valid_d = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q       <= '0;
            rptr_q       <= '0;
            rf_we_q      <= 1'b0;
            rf_waddr_q   <= '0;
            rf_wdata_q   <= '0;
            rf_raddr1_q  <= '0;
            rf_raddr2_q  <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_rdata1_q <= '0;
            rsp_rdata2_q <= '0;
            wr_zero_q    <= 1'b0;
        end else begin
            wptr_q       <= wptr_d;
            rptr_q       <= rptr_d;
            rf_we_q      <= rf_we_d;
            rf_waddr_q   <= rf_waddr_d;
            rf_wdata_q   <= rf_wdata_d;
            rf_raddr1_q  <= rf_raddr1_d;
            rf_raddr2_q  <= rf_raddr2_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_rdata1_q <= rsp_rdata1_d;
            rsp_rdata2_q <= rsp_rdata2_d;
            wr_zero_q    <= wr_zero_d;
        end
    end

    assign cmd_ready_o  = !full;
    assign rsp_valid_o  = rsp_valid_q;
    assign rsp_rdata1_o = rsp_rdata1_q;
    assign rsp_rdata2_o = rsp_rdata2_q;
    assign rf_we_o      = rf_we_q;
    assign rf_waddr_o   = rf_waddr_q;
    assign rf_wdata_o   = rf_wdata_q;
    assign rf_raddr1_o  = rf_raddr1_q;
    assign rf_raddr2_o  = rf_raddr2_q;
    assign busy_o       = !empty || (state_q != IDLE);
    assign wr_zero_o    = wr_zero_q;

endmodule

// File: tb/tb_regfile_access_ctrl.sv
// Bench for regfile_access_ctrl: directed steps plus random traffic,
// checked against an in-order shadow register model and expected-response queue.
module tb_regfile_access_ctrl;

    logic        clk = 1'b0;
    logic        rst_ni = 1'b0;
    logic        cmd_valid_i = 1'b0;
    logic        cmd_ready_o;
    logic        cmd_write_i = 1'b0;
    logic [4:0]  cmd_addr1_i = '0;
    logic [4:0]  cmd_addr2_i = '0;
    logic [31:0] cmd_wdata_i = '0;
    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic [31:0] rsp_rdata1_o, rsp_rdata2_o;
    logic        rf_we_o;
    logic [4:0]  rf_waddr_o, rf_raddr1_o, rf_raddr2_o;
    logic [31:0] rf_wdata_o, rf_rdata1_i, rf_rdata2_i;
    logic        busy_o, wr_zero_o;

    logic        rdy_fixed = 1'b1;
    logic        rand_rdy = 1'b0;
    logic        rnd_bit = 1'b1;
    logic        mem_init = 1'b0;

    logic [31:0] rf_mem [32];
    logic [31:0] shadow [32];
    logic [63:0] exp_q [$];

    int errors = 0;
    int checks = 0;
    int we_cnt = 0;
    int rsp_cnt = 0;
    int wr_pushed = 0;
    int rd_pushed = 0;
    logic prev_we = 1'b0;

    always #5 clk = ~clk;

    assign rsp_ready_i = rand_rdy ? rnd_bit : rdy_fixed;

    regfile_access_ctrl #(
        .ADDR_WIDTH(5),
        .DATA_WIDTH(32),
        .FIFO_DEPTH(4)
    ) dut (
        .clk_i(clk),
        .rst_ni(rst_ni),
        .cmd_valid_i(cmd_valid_i),
        .cmd_ready_o(cmd_ready_o),
        .cmd_write_i(cmd_write_i),
        .cmd_addr1_i(cmd_addr1_i),
        .cmd_addr2_i(cmd_addr2_i),
        .cmd_wdata_i(cmd_wdata_i),
        .rsp_valid_o(rsp_valid_o),
        .rsp_ready_i(rsp_ready_i),
        .rsp_rdata1_o(rsp_rdata1_o),
        .rsp_rdata2_o(rsp_rdata2_o),
        .rf_we_o(rf_we_o),
        .rf_waddr_o(rf_waddr_o),
        .rf_wdata_o(rf_wdata_o),
        .rf_raddr1_o(rf_raddr1_o),
        .rf_raddr2_o(rf_raddr2_o),
        .rf_rdata1_i(rf_rdata1_i),
        .rf_rdata2_i(rf_rdata2_i),
        .busy_o(busy_o),
        .wr_zero_o(wr_zero_o)
    );

    // Attached register file: x0 reads zero and ignores writes
    assign rf_rdata1_i = (rf_raddr1_o == 0) ? 32'h0 : rf_mem[rf_raddr1_o];
    assign rf_rdata2_i = (rf_raddr2_o == 0) ? 32'h0 : rf_mem[rf_raddr2_o];

    always @(posedge clk) begin
        if (!mem_init) begin
            for (int i = 0; i < 32; i++) rf_mem[i] <= 32'h0;
        end else if (rf_we_o && rf_waddr_o != 0) begin
            rf_mem[rf_waddr_o] <= rf_wdata_o;
        end
    end

    always @(negedge clk) rnd_bit <= 1'($urandom_range(0, 1));

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Response monitor: consumed responses must match the model in order
    always @(negedge clk) begin
        logic [63:0] e;
        #1;
        if (rst_ni) begin
            if (rf_we_o) begin
                we_cnt++;
                chk("we_single_cycle", 64'(prev_we), 64'd0);
            end
            prev_we = rf_we_o;
            if (rsp_valid_o && rsp_ready_i) begin
                chk("rsp_expected", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("rsp_rdata1", 64'(rsp_rdata1_o), 64'(e[63:32]));
                    chk("rsp_rdata2", 64'(rsp_rdata2_o), 64'(e[31:0]));
                    rsp_cnt++;
                end
            end
        end else begin
            prev_we = 1'b0;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic push(input bit w, input logic [4:0] a1,
                        input logic [4:0] a2, input logic [31:0] d);
        int t;
        cmd_valid_i = 1'b1;
        cmd_write_i = w;
        cmd_addr1_i = a1;
        cmd_addr2_i = a2;
        cmd_wdata_i = d;
        t = 0;
        while (!cmd_ready_o && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("push_timeout", 64'(t < 200), 64'd1);
        @(negedge clk);
        cmd_valid_i = 1'b0;
        if (w) begin
            if (a1 != 0) shadow[a1] = d;
            wr_pushed++;
        end else begin
            exp_q.push_back({shadow[a1], shadow[a2]});
            rd_pushed++;
        end
    endtask

    task automatic wait_idle(input string tag);
        int t;
        t = 0;
        while ((busy_o || rsp_valid_o || exp_q.size() != 0) && t < 1000) begin
            @(negedge clk);
            t++;
        end
        chk(tag, 64'(t < 1000), 64'd1);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ready"}, 64'(cmd_ready_o), 64'd1);
        chk({tag, "_rsp_valid"}, 64'(rsp_valid_o), 64'd0);
        chk({tag, "_rdata1"}, 64'(rsp_rdata1_o), 64'd0);
        chk({tag, "_rdata2"}, 64'(rsp_rdata2_o), 64'd0);
        chk({tag, "_we"}, 64'(rf_we_o), 64'd0);
        chk({tag, "_waddr"}, 64'(rf_waddr_o), 64'd0);
        chk({tag, "_wdata"}, 64'(rf_wdata_o), 64'd0);
        chk({tag, "_raddr1"}, 64'(rf_raddr1_o), 64'd0);
        chk({tag, "_raddr2"}, 64'(rf_raddr2_o), 64'd0);
        chk({tag, "_busy"}, 64'(busy_o), 64'd0);
        chk({tag, "_wr_zero"}, 64'(wr_zero_o), 64'd0);
    endtask

    initial begin
        logic [31:0] old5;
        int t;
        for (int i = 0; i < 32; i++) shadow[i] = 32'h0;

        // Reset
        repeat (3) @(negedge clk);
        mem_init = 1'b1;
        chk_reset_outputs("rst_low");
        rst_ni = 1'b1;
        @(negedge clk);
        chk_reset_outputs("rst_rel");

        // Write latency then read latency
        push(1'b1, 5'd3, 5'd0, 32'hDEAD_BEEF);
        chk("wlat_n", 64'(rf_we_o), 64'd0);
        @(negedge clk);
        chk("wlat_we", 64'(rf_we_o), 64'd1);
        chk("wlat_waddr", 64'(rf_waddr_o), 64'd3);
        chk("wlat_wdata", 64'(rf_wdata_o), 64'hDEAD_BEEF);
        @(negedge clk);
        chk("wlat_we_drop", 64'(rf_we_o), 64'd0);
        chk("wlat_commit", 64'(rf_mem[3]), 64'hDEAD_BEEF);
        wait_idle("idle_t1w");
        push(1'b0, 5'd3, 5'd0, 32'h0);
        chk("rlat_n", 64'(rsp_valid_o), 64'd0);
        @(negedge clk);
        chk("rlat_n1", 64'(rsp_valid_o), 64'd0);
        chk("rlat_raddr1", 64'(rf_raddr1_o), 64'd3);
        @(negedge clk);
        chk("rlat_n2", 64'(rsp_valid_o), 64'd1);
        chk("rlat_d1", 64'(rsp_rdata1_o), 64'hDEAD_BEEF);
        chk("rlat_d2", 64'(rsp_rdata2_o), 64'd0);
        wait_idle("idle_t1r");

        // Write to x0
        push(1'b1, 5'd0, 5'd0, 32'h1);
        wait_idle("idle_wz");
        chk("wr_zero_set", 64'(wr_zero_o), 64'd1);
        push(1'b0, 5'd0, 5'd0, 32'h0);
        wait_idle("idle_wz_rd");

        // Backpressure fill: one in flight plus four buffered
        rdy_fixed = 1'b0;
        push(1'b0, 5'd3, 5'd0, 32'h0);
        push(1'b1, 5'd7, 5'd0, 32'h77);
        push(1'b0, 5'd7, 5'd3, 32'h0);
        push(1'b1, 5'd7, 5'd0, 32'h78);
        push(1'b0, 5'd7, 5'd0, 32'h0);
        chk("fill_full", 64'(cmd_ready_o), 64'd0);
        cmd_valid_i = 1'b1;
        cmd_write_i = 1'b1;
        cmd_addr1_i = 5'd9;
        cmd_wdata_i = 32'h99;
        repeat (3) @(negedge clk);
        chk("fill_hold_ready", 64'(cmd_ready_o), 64'd0);
        chk("fill_hold_valid", 64'(rsp_valid_o), 64'd1);
        chk("fill_hold_d1", 64'(rsp_rdata1_o), 64'hDEAD_BEEF);
        rdy_fixed = 1'b1;
        push(1'b1, 5'd9, 5'd0, 32'h99);
        chk("fill_refull", 64'(cmd_ready_o), 64'd0);
        push(1'b0, 5'd9, 5'd7, 32'h0);
        wait_idle("idle_fill");
        chk("wr_zero_sticky", 64'(wr_zero_o), 64'd1);

        // Interleaved writes and reads across all addresses
        we_cnt = 0;
        for (int a = 1; a < 32; a++) begin
            push(1'b1, 5'(a), 5'd0, 32'(a) * 32'h0101_0101);
            push(1'b0, 5'(a), 5'(a - 1), 32'h0);
        end
        wait_idle("idle_ilv");
        chk("ilv_we_count", 64'(we_cnt), 64'd31);
        chk("ilv_mem31", 64'(rf_mem[31]), 64'h1F1F_1F1F);

        // Random traffic with random response backpressure
        we_cnt = 0;
        wr_pushed = 0;
        rd_pushed = 0;
        rsp_cnt = 0;
        rand_rdy = 1'b1;
        for (int n = 0; n < 200; n++) begin
            push(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                 5'($urandom_range(0, 31)), $urandom);
            if ($urandom_range(0, 3) == 0) @(negedge clk);
        end
        wait_idle("idle_rand");
        rand_rdy = 1'b0;
        chk("rand_we_count", 64'(we_cnt), 64'(wr_pushed));
        chk("rand_rsp_count", 64'(rsp_cnt), 64'(rd_pushed));

        // Reset during WRITE: the write must not land
        old5 = shadow[5];
        push(1'b1, 5'd5, 5'd0, 32'hA5A5_0005);
        @(negedge clk);
        chk("abort_w_we", 64'(rf_we_o), 64'd1);
        rst_ni = 1'b0;
        #1;
        chk_reset_outputs("abort_w");
        shadow[5] = old5;
        @(negedge clk);
        rst_ni = 1'b1;
        repeat (3) @(negedge clk);
        chk("abort_w_mem", 64'(rf_mem[5]), 64'(old5));
        chk("abort_w_busy", 64'(busy_o), 64'd0);

        // Reset during RESP with commands still buffered
        rdy_fixed = 1'b0;
        push(1'b0, 5'd3, 5'd5, 32'h0);
        push(1'b0, 5'd4, 5'd6, 32'h0);
        push(1'b0, 5'd8, 5'd9, 32'h0);
        t = 0;
        while (!rsp_valid_o && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk("abort_r_valid", 64'(rsp_valid_o), 64'd1);
        rst_ni = 1'b0;
        #1;
        chk_reset_outputs("abort_r");
        exp_q.delete();
        @(negedge clk);
        rst_ni = 1'b1;
        rdy_fixed = 1'b1;
        repeat (5) @(negedge clk);
        chk("abort_r_drop", 64'(busy_o), 64'd0);
        chk("abort_r_norsp", 64'(rsp_valid_o), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
